tea_decrypt: RTL
================

TEA_DECRYPT -- requirements
Module: tea_decrypt

Interface
REQ-001 Parameter ROUNDS, default 32: number of TEA decryption rounds, range 1..63.
REQ-002 Parameter DELTA, default 32'h9E3779B9: TEA key-schedule constant.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: request to decrypt idata with key; sampled on the rising edge.
REQ-006 Port idata, input, 64: ciphertext; [63:32]=v0, [31:0]=v1.
REQ-007 Port key, input, 128: key; [127:96]=k0, [95:64]=k1, [63:32]=k2, [31:0]=k3.
REQ-008 Port busy, output, 1: high while a decryption is in progress.
REQ-009 Port valid, output, 1: one-cycle pulse when odata is updated with a new result.
REQ-010 Port odata, output, 64: plaintext; [63:32]=v0, [31:0]=v1; holds its value until the next result.

Function
REQ-011 FSM shall have two states: IDLE (busy=0) and RUN (busy=1).
REQ-012 IDLE with start=1 at an edge shall, at that edge: latch idata into v0/v1; latch key into the internal key register; load sum=(DELTA*ROUNDS) mod 2^32 (0xC6EF3720 for the defaults); clear the round counter; enter RUN.
REQ-013 Each RUN edge shall execute exactly one round, in order, all arithmetic mod 2^32:
  - v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
  - v0 -= ((v1new<<4)+k0) ^ (v1new+sum) ^ ((v1new>>5)+k1)
  - sum -= DELTA
  - counter += 1
REQ-014 Shifts shall be logical; all carries and borrows beyond bit 31 shall be discarded.
REQ-015 On the edge completing round ROUNDS, the block shall write {v0,v1} to odata, pulse valid high for exactly one cycle, and return to IDLE.
REQ-016 Latency: start sampled at edge N gives valid=1 in the cycle after edge N+ROUNDS.
REQ-017 start while busy=1 shall be ignored; idata and key changes during RUN shall not affect the result.
REQ-018 start=1 in the same cycle as valid=1 shall be accepted (back-to-back operation); the new start shall not alter the odata just produced.
REQ-019 valid shall never be asserted without a preceding accepted start.

Reset
REQ-020 rst=0 shall immediately, regardless of clock, force: state=IDLE; busy=0; valid=0; odata=64'h0; counter, sum, v0, v1 and key registers to 0.
REQ-021 Reset during RUN shall abort the operation; no valid pulse shall follow for the aborted operation.
REQ-022 After rst deasserts, the first start shall be honoured at the first rising edge at which it is sampled.

Configuration
REQ-023 Macro TEA_DEC_ABORT_EN, when defined, shall add input port abort (1 bit).
REQ-024 With TEA_DEC_ABORT_EN defined, abort=1 at an edge during RUN shall return the block to IDLE with valid=0 and odata unchanged.
REQ-025 With TEA_DEC_ABORT_EN defined, abort=1 in IDLE shall have no effect, and abort shall take priority over a start in the same cycle.
REQ-026 With TEA_DEC_ABORT_EN undefined, the abort port shall not exist and behaviour shall be exactly REQ-011..REQ-022.

Verification
REQ-027 Known answer: key=0, idata=64'h41EA3A0A_94BAA940, start pulse -> valid after 32 edges, odata=64'h0000000000000000.
REQ-028 Round trip: 100 random {plaintext, key} pairs encrypted by a TEA reference model, then decrypted -> each odata equals its plaintext, each valid exactly 32 cycles after start.
REQ-029 Busy-ignore: a second start with different idata and key at cycle 10 of RUN -> a single valid pulse carrying the first result; busy stays high through cycle 32.
REQ-030 Back-to-back: start held high continuously -> valid pulses every 33 cycles; odata correct for each vector.
REQ-031 Reset mid-run: rst=0 at round 15 -> outputs zero immediately, no valid pulse; a new start afterwards -> correct result with full 32-round latency.
REQ-032 With TEA_DEC_ABORT_EN: abort at round 5 -> busy=0 on the next cycle, no valid pulse, odata keeps its previous result.

Source files
------------

// File: rtl/tea_decrypt.sv
// TEA block decryptor: one Feistel round pair per clock, iterative datapath.
// Latency: start sampled at edge N -> valid pulse in the cycle after edge N+ROUNDS.
// Backpressure: none; start is ignored while busy, results must be taken on valid.
//
// Ports:
//   clk    - core clock, rising edge
//   rst    - asynchronous active-low reset
//   start  - decrypt request, accepted only in IDLE
//   idata  - ciphertext {v0, v1}
//   key    - 128-bit key {k0, k1, k2, k3}
//   abort  - (only with TEA_DEC_ABORT_EN) cancel a running decryption
//   busy   - high while a decryption is in progress
//   valid  - one-cycle pulse when odata carries a new result
//   odata  - plaintext {v0, v1}, held until the next result
//
// Optional feature: define TEA_DEC_ABORT_EN to add the abort input.
module tea_decrypt #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  idata,
    input  logic [127:0] key,
`ifdef TEA_DEC_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         valid,
    output logic [63:0]  odata
);

    // Starting sum is DELTA*ROUNDS truncated to 32 bits; compute it wide
    // so the truncation is explicit rather than a side effect of int math.
    localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0] SUM_INIT = SUM_PROD[31:0];
    localparam logic [5:0]  LAST_RND = 6'(ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic [31:0]    r_v0;
    logic [31:0]    r_v1;
    logic [31:0]    r_sum;
    logic [127:0]   r_key;
    logic [5:0]     r_cnt;
    logic           r_valid;
    logic [63:0]    r_odata;

    logic [31:0]    w_v0_nxt;
    logic [31:0]    w_v1_nxt;
    logic           w_abort;

`ifdef TEA_DEC_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // TEA mixing function; shifts are logical and all sums wrap at 32 bits.
    function automatic logic [31:0] tea_f(
        input logic [31:0] v,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // v1 is updated first; the v0 update uses the already-updated v1.
    assign w_v1_nxt = r_v1 - tea_f(r_v0, r_sum, r_key[63:32], r_key[31:0]);
    assign w_v0_nxt = r_v0 - tea_f(w_v1_nxt, r_sum, r_key[127:96], r_key[95:64]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_v0    <= '0;
            r_v1    <= '0;
            r_sum   <= '0;
            r_key   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_odata <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // abort outranks a simultaneous start
                    if (start && !w_abort) begin
                        r_v0    <= idata[63:32];
                        r_v1    <= idata[31:0];
                        r_key   <= key;
                        r_sum   <= SUM_INIT;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_v0  <= w_v0_nxt;
                        r_v1  <= w_v1_nxt;
                        r_sum <= r_sum - DELTA;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == LAST_RND) begin
                            r_odata <= {w_v0_nxt, w_v1_nxt};
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state == RUN);
    assign valid = r_valid;
    assign odata = r_odata;

endmodule
